// File: rtl/active_list.sv
`default_nettype none
// ============================================================================
// Module   : active_list
// Purpose  : In-order active list (reorder buffer) for the rename stage.
//            Allocates one entry per renamed instruction, retires entries in
//            program order once complete (returning the previous physical
//            register to the free list), and on a mispredict walks back from
//            the youngest entry, one per cycle, restoring the map table.
// Ports    : clk, rst                      - clock, synchronous active-high reset
//            alloc_*                       - allocation request / ready / tag
//            complete_valid/complete_tag   - execution-complete notification
//            commit_valid/commit_tag       - head retirement
//            free_valid/free_preg          - physical register returned
//            flush_valid/flush_tag         - mispredict, squash younger entries
//            restore_valid/lreg/preg       - map-table undo write
//            recovering                    - walk-back in progress
// Config   : ACTIVE_LIST_SAME_CYCLE_COMMIT_EN - when defined, a completion
//            aimed at the head lets it commit in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module active_list #(
  parameter int DEPTH  = 32,
  parameter int PREG_W = 6,
  parameter int LREG_W = 5,
  parameter int TAG_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic              alloc_uses_rw,
  input  logic [LREG_W-1:0] alloc_lreg,
  input  logic [PREG_W-1:0] alloc_prev_preg,
  input  logic [PREG_W-1:0] alloc_new_preg,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              complete_valid,
  input  logic [TAG_W-1:0]  complete_tag,
  output logic              free_valid,
  output logic [PREG_W-1:0] free_preg,
  output logic              commit_valid,
  output logic [TAG_W-1:0]  commit_tag,
  input  logic              flush_valid,
  input  logic [TAG_W-1:0]  flush_tag,
  output logic              restore_valid,
  output logic [LREG_W-1:0] restore_lreg,
  output logic [PREG_W-1:0] restore_preg,
  output logic              recovering
);

  localparam logic [0:0]       ST_IDLE    = 1'b0;
  localparam logic [0:0]       ST_RECOVER = 1'b1;
  localparam logic [TAG_W-1:0] C_TAG_ONE  = (TAG_W)'(1);
  localparam logic [TAG_W:0]   C_CNT_ONE  = (TAG_W+1)'(1);
  localparam logic [TAG_W:0]   C_CNT_FULL = (TAG_W+1)'(DEPTH);

  // Entry storage
  logic [DEPTH-1:0]  uses_rw_q;
  logic [DEPTH-1:0]  done_q;
  logic [LREG_W-1:0] lreg_q      [DEPTH];
  logic [PREG_W-1:0] prev_preg_q [DEPTH];
  logic [PREG_W-1:0] new_preg_q  [DEPTH];

  // Control state
  logic [0:0]       state_q, state_d;
  logic [TAG_W-1:0] head_q,  head_d;
  logic [TAG_W-1:0] tail_q,  tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic [TAG_W-1:0] walk_q,  walk_d;
  logic [TAG_W-1:0] stop_q,  stop_d;

  logic             is_idle;
  logic [TAG_W-1:0] tail_m1;
  logic [TAG_W-1:0] cmp_off;
  logic [TAG_W-1:0] flush_off;
  logic             cmp_in_range;
  logic             flush_in_range;
  logic             head_done;
  logic             do_commit;
  logic             do_alloc;
  logic             do_flush;

  assign is_idle = (state_q == ST_IDLE);
  assign tail_m1 = tail_q - C_TAG_ONE;

  // A tag is live when its distance from the head is below the occupancy;
  // this handles wrap-around without comparing head and tail directly.
  assign cmp_off        = complete_tag - head_q;
  assign cmp_in_range   = ({1'b0, cmp_off} < count_q);
  assign flush_off      = flush_tag - head_q;
  assign flush_in_range = ({1'b0, flush_off} < count_q);

`ifdef ACTIVE_LIST_SAME_CYCLE_COMMIT_EN
  assign head_done = done_q[head_q] | (complete_valid && (complete_tag == head_q));
`else
  assign head_done = done_q[head_q];
`endif

  assign alloc_ready = is_idle && (count_q < C_CNT_FULL) && !flush_valid;
  assign do_alloc    = alloc_valid && alloc_ready;
  assign do_commit   = is_idle && (count_q != '0) && head_done;
  // A branch tag that is not live cannot own any younger entries, so such a
  // flush is dropped rather than walking stale slots.
  assign do_flush    = is_idle && flush_valid && flush_in_range && (flush_tag != tail_m1);

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    walk_d  = walk_q;
    stop_d  = stop_q;
    if (state_q == ST_IDLE) begin
      if (do_commit) head_d = head_q + C_TAG_ONE;
      if (do_alloc)  tail_d = tail_q + C_TAG_ONE;
      case ({do_alloc, do_commit})
        2'b10:   count_d = count_q + C_CNT_ONE;
        2'b01:   count_d = count_q - C_CNT_ONE;
        default: count_d = count_q;
      endcase
      if (do_flush) begin
        state_d = ST_RECOVER;
        walk_d  = tail_m1;
        stop_d  = flush_tag;
      end
    end else begin
      // Each walk step pops the youngest entry off the tail.
      tail_d  = walk_q;
      count_d = count_q - C_CNT_ONE;
      walk_d  = walk_q - C_TAG_ONE;
      if (walk_q == stop_q + C_TAG_ONE) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      walk_q  <= '0;
      stop_q  <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      walk_q  <= walk_d;
      stop_q  <= stop_d;
      if (complete_valid && cmp_in_range) done_q[complete_tag] <= 1'b1;
      if (do_alloc)                        done_q[tail_q]       <= 1'b0;
    end
  end

  // Payload needs no reset: an entry is only read while it is live.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      uses_rw_q[tail_q]   <= alloc_uses_rw;
      lreg_q[tail_q]      <= alloc_lreg;
      prev_preg_q[tail_q] <= alloc_prev_preg;
      new_preg_q[tail_q]  <= alloc_new_preg;
    end
  end

  assign alloc_tag     = tail_q;
  assign commit_valid  = do_commit;
  assign commit_tag    = head_q;
  assign recovering    = (state_q == ST_RECOVER);
  // Retirement frees the old mapping; a squash frees the speculative one.
  assign free_valid    = recovering ? uses_rw_q[walk_q] : (do_commit && uses_rw_q[head_q]);
  assign free_preg     = recovering ? new_preg_q[walk_q] : prev_preg_q[head_q];
  assign restore_valid = recovering && uses_rw_q[walk_q];
  assign restore_lreg  = lreg_q[walk_q];
  assign restore_preg  = prev_preg_q[walk_q];

endmodule
`default_nettype wire

// File: tb/tb_active_list.sv
`default_nettype none
// ============================================================================
// Module   : tb_active_list
// Purpose  : Directed self-checking bench for active_list (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_active_list;

`ifdef ACTIVE_LIST_SAME_CYCLE_COMMIT_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_valid, alloc_ready, alloc_uses_rw;
  logic [4:0] alloc_lreg;
  logic [5:0] alloc_prev_preg, alloc_new_preg;
  logic [4:0] alloc_tag;
  logic       complete_valid;
  logic [4:0] complete_tag;
  logic       free_valid;
  logic [5:0] free_preg;
  logic       commit_valid;
  logic [4:0] commit_tag;
  logic       flush_valid;
  logic [4:0] flush_tag;
  logic       restore_valid;
  logic [4:0] restore_lreg;
  logic [5:0] restore_preg;
  logic       recovering;

  int checks   = 0;
  int failures = 0;

  active_list dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_uses_rw(alloc_uses_rw),
    .alloc_lreg(alloc_lreg), .alloc_prev_preg(alloc_prev_preg), .alloc_new_preg(alloc_new_preg),
    .alloc_tag(alloc_tag), .complete_valid(complete_valid), .complete_tag(complete_tag),
    .free_valid(free_valid), .free_preg(free_preg), .commit_valid(commit_valid),
    .commit_tag(commit_tag), .flush_valid(flush_valid), .flush_tag(flush_tag),
    .restore_valid(restore_valid), .restore_lreg(restore_lreg), .restore_preg(restore_preg),
    .recovering(recovering)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alloc_valid = 0; alloc_uses_rw = 0; alloc_lreg = 0; alloc_prev_preg = 0; alloc_new_preg = 0;
    complete_valid = 0; complete_tag = 0; flush_valid = 0; flush_tag = 0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic set_alloc(input logic u, input logic [4:0] l, input logic [5:0] p, input logic [5:0] n);
    alloc_valid = 1; alloc_uses_rw = u; alloc_lreg = l; alloc_prev_preg = p; alloc_new_preg = n;
  endtask

  task automatic test_reset();
    reset_dut();
    #1;
    checks++; if (alloc_ready !== 1'b1) begin failures++; $display("FAIL reset_alloc_ready got=%0h exp=1", alloc_ready); end
    checks++; if (alloc_tag !== 5'd0) begin failures++; $display("FAIL reset_alloc_tag got=%0h exp=0", alloc_tag); end
    checks++; if ({free_valid, commit_valid, restore_valid, recovering} !== 4'b0) begin failures++;
      $display("FAIL reset_valids got=%b exp=0000", {free_valid, commit_valid, restore_valid, recovering}); end
    checks++; if (commit_tag !== 5'd0) begin failures++; $display("FAIL reset_commit_tag got=%0h exp=0", commit_tag); end
    checks++; if (dut.count_q !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", dut.count_q); end
  endtask

  task automatic test_alloc();
    logic [4:0] lr [3] = '{5'd5, 5'd6, 5'd5};
    logic [5:0] pv [3] = '{6'd5, 6'd6, 6'd40};
    logic [5:0] nw [3] = '{6'd40, 6'd41, 6'd42};
    for (int i = 0; i < 3; i++) begin
      set_alloc(1'b1, lr[i], pv[i], nw[i]);
      #1;
      checks++; if (alloc_ready !== 1'b1 || alloc_tag !== 5'(i)) begin failures++;
        $display("FAIL alloc_tag%0d got ready=%0h tag=%0d exp ready=1 tag=%0d", i, alloc_ready, alloc_tag, i); end
      tick();
    end
    clear_inputs();
    #1;
    checks++; if (dut.count_q !== 6'd3) begin failures++; $display("FAIL alloc_count got=%0d exp=3", dut.count_q); end
  endtask

  task automatic test_commit_order();
    logic [4:0] etag;
    logic [5:0] epreg;
    // Cycle A: tag 1 completes out of order
    complete_valid = 1; complete_tag = 5'd1; #1;
    checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL commit_A_valid got=%0h exp=0", commit_valid); end
    tick();
    // Cycle B: head completes
    complete_tag = 5'd0; #1;
    checks++; if (commit_valid !== BYP) begin failures++; $display("FAIL commit_B_valid got=%0h exp=%0h", commit_valid, BYP); end
    tick();
    // Cycle C
    clear_inputs(); #1;
    etag  = BYP ? 5'd1 : 5'd0;
    epreg = BYP ? 6'd6 : 6'd5;
    checks++; if (commit_valid !== 1'b1 || commit_tag !== etag) begin failures++;
      $display("FAIL commit_C got valid=%0h tag=%0d exp valid=1 tag=%0d", commit_valid, commit_tag, etag); end
    checks++; if (free_valid !== 1'b1 || free_preg !== epreg) begin failures++;
      $display("FAIL commit_C_free got valid=%0h preg=%0d exp valid=1 preg=%0d", free_valid, free_preg, epreg); end
    tick();
    // Cycle D
    #1;
    etag = BYP ? 5'd2 : 5'd1;
    checks++; if (commit_valid !== !BYP || commit_tag !== etag) begin failures++;
      $display("FAIL commit_D got valid=%0h tag=%0d exp valid=%0h tag=%0d", commit_valid, commit_tag, !BYP, etag); end
    tick();
    // Cycle E: tag 2 never completed
    #1;
    checks++; if (commit_valid !== 1'b0 || commit_tag !== 5'd2) begin failures++;
      $display("FAIL commit_E got valid=%0h tag=%0d exp valid=0 tag=2", commit_valid, commit_tag); end
  endtask

  task automatic test_full();
    reset_dut();
    for (int i = 0; i < 32; i++) begin
      set_alloc(i != 0, 5'(i), 6'(i), 6'(32 + i));
      #1;
      checks++; if (alloc_tag !== 5'(i) || alloc_ready !== 1'b1) begin failures++;
        $display("FAIL full_fill%0d got ready=%0h tag=%0d exp ready=1 tag=%0d", i, alloc_ready, alloc_tag, i); end
      tick();
    end
    #1;
    checks++; if (alloc_ready !== 1'b0 || alloc_tag !== 5'd0) begin failures++;
      $display("FAIL full_ready got ready=%0h tag=%0d exp ready=0 tag=0", alloc_ready, alloc_tag); end
    tick();
    alloc_valid = 0; complete_valid = 1; complete_tag = 5'd0; #1;
    checks++; if (commit_valid !== BYP || free_valid !== 1'b0) begin failures++;
      $display("FAIL full_cmpl got commit=%0h free=%0h exp commit=%0h free=0", commit_valid, free_valid, BYP); end
    tick();
    complete_valid = 0; #1;
    checks++; if (commit_valid !== !BYP || free_valid !== 1'b0 || alloc_ready !== BYP) begin failures++;
      $display("FAIL full_next got commit=%0h free=%0h ready=%0h exp commit=%0h free=0 ready=%0h",
               commit_valid, free_valid, alloc_ready, !BYP, BYP); end
    tick();
    set_alloc(1'b1, 5'd7, 6'd7, 6'd50); #1;
    checks++; if (alloc_ready !== 1'b1 || alloc_tag !== 5'd0) begin failures++;
      $display("FAIL full_wrap got ready=%0h tag=%0d exp ready=1 tag=0", alloc_ready, alloc_tag); end
    tick();
    alloc_valid = 0; #1;
    checks++; if (alloc_ready !== 1'b0 || alloc_tag !== 5'd1) begin failures++;
      $display("FAIL full_refull got ready=%0h tag=%0d exp ready=0 tag=1", alloc_ready, alloc_tag); end
  endtask

  task automatic test_flush();
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      set_alloc(1'b1, 5'(i + 1), 6'(10 + i), 6'(20 + i));
      tick();
    end
    clear_inputs();
    flush_valid = 1; flush_tag = 5'd1; #1;
    checks++; if (alloc_ready !== 1'b0 || recovering !== 1'b0) begin failures++;
      $display("FAIL flush_cycle got ready=%0h rec=%0h exp ready=0 rec=0", alloc_ready, recovering); end
    tick();
    flush_valid = 0;
    for (int r = 0; r < 3; r++) begin
      int t;
      t = 4 - r;
      #1;
      checks++; if (recovering !== 1'b1 || restore_valid !== 1'b1 || restore_lreg !== 5'(t + 1) ||
                    restore_preg !== 6'(10 + t)) begin failures++;
        $display("FAIL flush_restore%0d got rec=%0h rv=%0h lreg=%0d preg=%0d exp rec=1 rv=1 lreg=%0d preg=%0d",
                 t, recovering, restore_valid, restore_lreg, restore_preg, t + 1, 10 + t); end
      checks++; if (free_valid !== 1'b1 || free_preg !== 6'(20 + t) || alloc_ready !== 1'b0 || commit_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_free%0d got fv=%0h preg=%0d ready=%0h cv=%0h exp fv=1 preg=%0d ready=0 cv=0",
                 t, free_valid, free_preg, alloc_ready, commit_valid, 20 + t); end
      tick();
    end
    #1;
    checks++; if (recovering !== 1'b0 || restore_valid !== 1'b0 || alloc_ready !== 1'b1 || alloc_tag !== 5'd2) begin
      failures++;
      $display("FAIL flush_done got rec=%0h rv=%0h ready=%0h tag=%0d exp rec=0 rv=0 ready=1 tag=2",
               recovering, restore_valid, alloc_ready, alloc_tag); end
    checks++; if (dut.count_q !== 6'd2) begin failures++; $display("FAIL flush_count got=%0d exp=2", dut.count_q); end
  endtask

  task automatic test_no_squash();
    // tags 0,1 live; flush at youngest while an alloc is offered
    set_alloc(1'b1, 5'd9, 6'd9, 6'd60);
    flush_valid = 1; flush_tag = 5'd1; #1;
    checks++; if (alloc_ready !== 1'b0) begin failures++; $display("FAIL nosq_gate got=%0h exp=0", alloc_ready); end
    tick();
    clear_inputs(); #1;
    checks++; if (recovering !== 1'b0 || alloc_ready !== 1'b1 || alloc_tag !== 5'd2) begin failures++;
      $display("FAIL nosq_after got rec=%0h ready=%0h tag=%0d exp rec=0 ready=1 tag=2", recovering, alloc_ready, alloc_tag); end
  endtask

  task automatic test_reset_mid_recover();
    for (int i = 2; i < 5; i++) begin
      set_alloc(1'b1, 5'(i), 6'(i), 6'(30 + i));
      tick();
    end
    clear_inputs();
    flush_valid = 1; flush_tag = 5'd1;
    tick();
    flush_valid = 0; #1;
    checks++; if (recovering !== 1'b1) begin failures++; $display("FAIL rmr_rec1 got=%0h exp=1", recovering); end
    tick();
    rst = 1;
    tick();
    rst = 0; #1;
    checks++; if (recovering !== 1'b0 || restore_valid !== 1'b0 || free_valid !== 1'b0) begin failures++;
      $display("FAIL rmr_idle got rec=%0h rv=%0h fv=%0h exp 0 0 0", recovering, restore_valid, free_valid); end
    checks++; if (dut.count_q !== 6'd0 || alloc_tag !== 5'd0 || alloc_ready !== 1'b1) begin failures++;
      $display("FAIL rmr_empty got count=%0d tag=%0d ready=%0h exp 0 0 1", dut.count_q, alloc_tag, alloc_ready); end
    tick(); #1;
    checks++; if (restore_valid !== 1'b0) begin failures++; $display("FAIL rmr_later got=%0h exp=0", restore_valid); end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    set_alloc(1'b1, 5'd1, 6'd1, 6'd33);
    tick();
    // P: alloc tag 1 while the head completes
    set_alloc(1'b1, 5'd2, 6'd2, 6'd34);
    complete_valid = 1; complete_tag = 5'd0; #1;
    checks++; if (commit_valid !== BYP || alloc_tag !== 5'd1) begin failures++;
      $display("FAIL b2b_P got cv=%0h tag=%0d exp cv=%0h tag=1", commit_valid, alloc_tag, BYP); end
    tick();
    // Q: alloc tag 2
    complete_valid = 0;
    set_alloc(1'b1, 5'd3, 6'd3, 6'd35); #1;
    checks++; if (commit_valid !== !BYP || alloc_tag !== 5'd2) begin failures++;
      $display("FAIL b2b_Q got cv=%0h tag=%0d exp cv=%0h tag=2", commit_valid, alloc_tag, !BYP); end
    tick();
    clear_inputs(); #1;
    checks++; if (dut.count_q !== 6'd2 || commit_tag !== 5'd1 || alloc_tag !== 5'd3) begin failures++;
      $display("FAIL b2b_end got count=%0d head=%0d tail=%0d exp 2 1 3", dut.count_q, commit_tag, alloc_tag); end
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_alloc();
    test_commit_order();
    test_full();
    test_flush();
    test_no_squash();
    test_reset_mid_recover();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
